// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the FemtoRV32 peripheral bus bridge:
// FSM state encoding, timeout read-back pattern and default address map.
package soc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [31:0] ERR_RDATA     = 32'hDEAD_BEEF;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h0040_0000;
    localparam int          DEF_SLOT_BITS = 16;

    // Index width that stays legal for a single-slave build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soc_bus_decode.sv
// Combinational address decode: slot index within the peripheral window plus
// an in-window flag. The caller substitutes the default slave when out of window.
module soc_bus_decode
    import soc_bus_pkg::*;
#(
    parameter int          NUM_SLAVES = 7,
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          SLOT_BITS  = DEF_SLOT_BITS,
    localparam int         IDX_W      = idx_width(NUM_SLAVES)
) (
    input  logic [31:0]      addr,
    output logic [IDX_W-1:0] slot,
    output logic             in_win
);

    // The last slave has no window slot of its own: it owns everything else.
    localparam logic [31:0] WIN_SIZE = 32'(NUM_SLAVES - 1) << SLOT_BITS;

    logic [31:0] offset;

    always_comb begin
        offset = addr - BASE_ADDR;
        in_win = (addr >= BASE_ADDR) && (offset < WIN_SIZE);
        slot   = '0;
        for (int i = 0; i < NUM_SLAVES - 1; i++) begin
            if ((offset >> SLOT_BITS) == 32'(i)) begin
                slot = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/soc_bus_bridge.sv
// Registered transaction engine between the FemtoRV32 memory port and N slaves,
// with per-slave ready wait states. Watchdog built only when BUS_TIMEOUT_EN is defined.
module soc_bus_bridge
    import soc_bus_pkg::*;
#(
    parameter int          NUM_SLAVES     = 7,
    parameter logic [31:0] BASE_ADDR      = DEF_BASE_ADDR,
    parameter int          SLOT_BITS      = DEF_SLOT_BITS,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    input  logic [3:0]               mem_wmask,
    input  logic                     mem_rstrb,
    output logic [31:0]              mem_rdata,
    output logic                     mem_rbusy,
    output logic                     mem_wbusy,
    output logic [NUM_SLAVES-1:0]    slv_cs,
    output logic                     slv_rd,
    output logic                     slv_wr,
    output logic [31:0]              slv_addr,
    output logic [31:0]              slv_wdata,
    output logic [3:0]               slv_wmask,
    input  logic [32*NUM_SLAVES-1:0] slv_dout,
    input  logic [NUM_SLAVES-1:0]    slv_ready,
    input  logic                     err_clr,
    output logic                     bus_err,
    output logic [31:0]              err_addr,
    output state_t                   dbg_state
);

    localparam int          IDX_W   = idx_width(NUM_SLAVES);
    localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYCLES - 1);

    // Handshake: the CPU raises mem_rstrb or a nonzero mem_wmask for one cycle;
    // it is accepted only in IDLE. The selected slave completes by holding
    // slv_ready high in any REQ/WAIT cycle; that cycle's slv_dout is captured.

    state_t           state, state_nxt;
    logic [IDX_W-1:0] dec_slot, dec_idx, idx_q;
    logic             dec_in_win;
    logic             start, accept, active, timeout;
    logic             wr_q;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic [3:0]       wmask_q;
    logic             sel_ready;
    logic [31:0]      sel_dout;

    soc_bus_decode #(
        .NUM_SLAVES(NUM_SLAVES),
        .BASE_ADDR (BASE_ADDR),
        .SLOT_BITS (SLOT_BITS)
    ) u_decode (
        .addr  (mem_addr),
        .slot  (dec_slot),
        .in_win(dec_in_win)
    );

    assign dec_idx = dec_in_win ? dec_slot : IDX_W'(NUM_SLAVES - 1);
    assign start   = (|mem_wmask) | mem_rstrb;
    assign accept  = (state == ST_IDLE) && start;
    assign active  = (state == ST_REQ) || (state == ST_WAIT);

    always_comb begin
        sel_ready = 1'b0;
        sel_dout  = 32'h0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready = slv_ready[i];
                sel_dout  = slv_dout[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_REQ;
            ST_REQ, ST_WAIT: begin
                if (sel_ready)    state_nxt = ST_IDLE;
                else if (timeout) state_nxt = ST_ERR;
                else              state_nxt = ST_WAIT;
            end
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // All bus-facing controls decode from registered state and latched fields.
    always_comb begin
        slv_cs = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            slv_cs[i] = active && (idx_q == IDX_W'(i));
        end
        slv_rd    = (state == ST_REQ) && !wr_q;
        slv_wr    = (state == ST_REQ) && wr_q;
        slv_wmask = (active && wr_q) ? wmask_q : 4'h0;
        mem_rbusy = (state != ST_IDLE) && !wr_q;
        mem_wbusy = (state != ST_IDLE) && wr_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wmask_q <= 4'h0;
            rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                idx_q   <= dec_idx;
                wr_q    <= |mem_wmask;
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wmask_q <= mem_wmask;
            end
            if (active && sel_ready && !wr_q) begin
                rdata_q <= sel_dout;
            end else if ((state == ST_ERR) && !wr_q) begin
                rdata_q <= ERR_RDATA;
            end
        end
    end

    assign mem_rdata = rdata_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;
    assign dbg_state = state;

`ifdef BUS_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        bus_err_q;
    logic [31:0] err_addr_q;

    // Loaded on acceptance so the REQ cycle is the first counted cycle:
    // ERR lands exactly TIMEOUT_CYCLES cycles after REQ.
    assign timeout = (cnt_q == 16'h0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 16'h0;
        end else if (accept) begin
            cnt_q <= TO_LOAD;
        end else if (active && (cnt_q != 16'h0)) begin
            cnt_q <= cnt_q - 16'h1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_err_q  <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            if (state == ST_ERR) begin
                bus_err_q <= 1'b1;
                if (!bus_err_q) err_addr_q <= addr_q;
            end else if (err_clr) begin
                bus_err_q <= 1'b0;
            end
        end
    end

    assign bus_err  = bus_err_q;
    assign err_addr = err_addr_q;
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign bus_err    = 1'b0;
    assign err_addr   = 32'h0;
    assign unused_cfg = ^{err_clr, TO_LOAD};
`endif

endmodule
